// File: rtl/shift_sched_pkg.sv
// Shared types and constants for the shift_sched round-robin shifter scheduler.
// Optional rotate support is compiled in with SHIFT_SCHED_ROTATE_EN.
package shift_sched_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned AMT_W  = 3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

`ifdef SHIFT_SCHED_ROTATE_EN
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    CAPTURE  = 3'd2,
    RESP     = 3'd3,
    ISSUE2   = 3'd4,
    CAPTURE2 = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    RESP    = 3'd3
  } state_e;
`endif

  // Complementary amount for the second rotate pass: DATA_W - amt (amt is nonzero).
  function automatic logic [AMT_W-1:0] comp_amt(input logic [AMT_W-1:0] amt);
    logic [AMT_W:0] full;
    full = (AMT_W+1)'(DATA_W);
    return AMT_W'(full - {1'b0, amt});
  endfunction

endpackage

// File: rtl/shift_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_req
);

  always_comb begin
    logic          found;
    logic [IW-1:0] j;
    grant     = '0;
    grant_idx = '0;
    any_req   = |req;
    found     = 1'b0;
    j         = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = IW'((32'(ptr) + k) % N);
      if (!found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = j;
      end
    end
  end

endmodule

// File: rtl/shift_sched.sv
// Round-robin scheduler sharing one registered 8-bit shifter among NUM_REQ requesters.
// Define SHIFT_SCHED_ROTATE_EN to add two-pass rotate requests (req_rot).
module shift_sched
  import shift_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                      Clock,
  input  logic                      Reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  input  logic [AMT_W*NUM_REQ-1:0]  req_amt,
  input  logic [NUM_REQ-1:0]        req_dir,
  input  logic [NUM_REQ-1:0]        req_rot,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      busy,
  output logic [DATA_W-1:0]         sh_data_in,
  output logic [AMT_W-1:0]          sh_shift_amt,
  output logic                      sh_dir,
  input  logic [DATA_W-1:0]         sh_data_out
);

  state_e state, state_nxt;

  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               any_req;

  logic [DATA_W-1:0] data_arr [NUM_REQ];
  logic [AMT_W-1:0]  amt_arr  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[DATA_W*i +: DATA_W];
    assign amt_arr[i]  = req_amt[AMT_W*i +: AMT_W];
  end

`ifdef SHIFT_SCHED_ROTATE_EN
  logic rot_pend;
`else
  logic unused_rot;
  assign unused_rot = ^req_rot;
`endif

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .any_req   (any_req)
  );

  // State register
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and the combinational accept strobe
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          req_ready = gnt;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = CAPTURE;
`ifdef SHIFT_SCHED_ROTATE_EN
      CAPTURE: state_nxt = rot_pend ? ISSUE2 : RESP;
      ISSUE2:   state_nxt = CAPTURE2;
      CAPTURE2: state_nxt = RESP;
`else
      CAPTURE: state_nxt = RESP;
`endif
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand, pointer and result registers; sh_* hold their value outside ISSUE passes
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr          <= '0;
      sh_data_in   <= '0;
      sh_shift_amt <= '0;
      sh_dir       <= 1'b0;
      resp_id      <= '0;
      resp_data    <= '0;
      resp_valid   <= 1'b0;
      busy         <= 1'b0;
`ifdef SHIFT_SCHED_ROTATE_EN
      rot_pend     <= 1'b0;
`endif
    end else begin
      busy <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (any_req) begin
            sh_data_in   <= data_arr[gnt_idx];
            sh_shift_amt <= amt_arr[gnt_idx];
            sh_dir       <= req_dir[gnt_idx];
            resp_id      <= gnt_idx;
            ptr          <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
`ifdef SHIFT_SCHED_ROTATE_EN
            rot_pend     <= req_rot[gnt_idx] && (amt_arr[gnt_idx] != '0);
`endif
          end
        end
        CAPTURE: begin
          resp_data <= sh_data_out;
`ifdef SHIFT_SCHED_ROTATE_EN
          // Second pass shifts the opposite way by the complement; OR merges the halves.
          if (rot_pend) begin
            sh_dir       <= ~sh_dir;
            sh_shift_amt <= comp_amt(sh_shift_amt);
          end else begin
            resp_valid <= 1'b1;
          end
`else
          resp_valid <= 1'b1;
`endif
        end
`ifdef SHIFT_SCHED_ROTATE_EN
        CAPTURE2: begin
          resp_data  <= resp_data | sh_data_out;
          resp_valid <= 1'b1;
        end
`endif
        RESP: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sched.sv
// Scoreboard bench for shift_sched with a registered shifter model in the loop.
module tb_shift_sched;
  import shift_sched_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

`ifdef SHIFT_SCHED_ROTATE_EN
  localparam logic [7:0] ROT_L   = 8'h03;
  localparam logic [7:0] ROT_R   = 8'hC0;
  localparam int         ROT_LAT = 4;
`else
  localparam logic [7:0] ROT_L   = 8'h02;
  localparam logic [7:0] ROT_R   = 8'h40;
  localparam int         ROT_LAT = 2;
`endif

  logic                 Clock = 1'b0;
  logic                 Reset_n = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [3*NUM_REQ-1:0] req_amt = '0;
  logic [NUM_REQ-1:0]   req_dir = '0;
  logic [NUM_REQ-1:0]   req_rot = '0;
  logic                 resp_valid;
  logic                 resp_ready = 1'b1;
  logic [ID_W-1:0]      resp_id;
  logic [7:0]           resp_data;
  logic                 busy;
  logic [7:0]           sh_data_in;
  logic [2:0]           sh_shift_amt;
  logic                 sh_dir;
  logic [7:0]           sh_data_out = 8'h00;

  int vectors     = 0;
  int miscompares = 0;

  logic [ID_W-1:0] exp_id_q[$];
  logic [7:0]      exp_data_q[$];

  always #5 Clock = ~Clock;

  shift_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .req_amt      (req_amt),
    .req_dir      (req_dir),
    .req_rot      (req_rot),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_data    (resp_data),
    .busy         (busy),
    .sh_data_in   (sh_data_in),
    .sh_shift_amt (sh_shift_amt),
    .sh_dir       (sh_dir),
    .sh_data_out  (sh_data_out)
  );

  // External registered shifter
  always @(posedge Clock)
    sh_data_out <= (sh_dir == DIR_LEFT) ? (sh_data_in << sh_shift_amt) : (sh_data_in >> sh_shift_amt);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per completed response handshake
  initial begin
    logic [ID_W-1:0] eid;
    logic [7:0]      ed;
    forever begin
      @(negedge Clock);
      if (Reset_n && resp_valid && resp_ready) begin
        if (exp_id_q.size() == 0) begin
          check("resp_unexpected", 32'd1, 32'd0);
        end else begin
          eid = exp_id_q.pop_front();
          ed  = exp_data_q.pop_front();
          check("resp_id", 32'(resp_id), 32'(eid));
          check("resp_data", 32'(resp_data), 32'(ed));
        end
      end
    end
  end

  task automatic expect_resp(input int id, input logic [7:0] d);
    exp_id_q.push_back(ID_W'(id));
    exp_data_q.push_back(d);
  endtask

  task automatic set_req(input int id, input logic [7:0] d, input logic [2:0] a,
                         input logic dir, input logic rot);
    req_data[8*id +: 8] = d;
    req_amt[3*id +: 3]  = a;
    req_dir[id]         = dir;
    req_rot[id]         = rot;
    req_valid[id]       = 1'b1;
  endtask

  // Waits for an accept; returns the granted index (-1 on timeout), then steps past the edge
  task automatic wait_grant(output int g);
    g = -1;
    for (int k = 0; k < 40 && g < 0; k++) begin
      @(negedge Clock);
      for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) g = i;
    end
    if (g < 0) check("grant_timeout", 32'd0, 32'd1);
    else begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic single(input string tag, input int id, input logic [7:0] d, input logic [2:0] a,
                        input logic dir, input logic rot, input logic [7:0] exp_d, input int exp_lat);
    int g;
    int n;
    int extra;
    expect_resp(id, exp_d);
    set_req(id, d, a, dir, rot);
    wait_grant(g);
    req_valid[id] = 1'b0;
    check({tag, "_grant"}, 32'(g), 32'(id));
    n = 0;
    extra = 0;
    @(negedge Clock);
    while (!resp_valid && n < 20) begin
      if (req_ready != '0) extra++;
      @(negedge Clock);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_ready_outside_idle"}, 32'(extra), 32'd0);
    @(posedge Clock);
    #1;
  endtask

  initial begin
    int g;
    int n;
    int order [6];
    order = '{0, 1, 2, 3, 0, 1};

    // Reset values
    repeat (3) @(posedge Clock);
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_sh_data_in", 32'(sh_data_in), 32'd0);
    check("rst_sh_amt", 32'(sh_shift_amt), 32'd0);
    check("rst_resp_data", 32'(resp_data), 32'd0);
    @(negedge Clock);
    Reset_n = 1'b1;
    @(posedge Clock);
    #1;

    // Basic shift and edge amounts
    single("t1", 2, 8'h81, 3'd1, DIR_LEFT, 1'b0, 8'h02, 2);
    single("edge_r7", 0, 8'h80, 3'd7, DIR_RIGHT, 1'b0, 8'h01, 2);
    single("edge_r0", 0, 8'h80, 3'd0, DIR_RIGHT, 1'b0, 8'h80, 2);

    // Rotate requests (plain shifts when the feature is compiled out)
    single("rot_l", 2, 8'h81, 3'd1, DIR_LEFT, 1'b1, ROT_L, ROT_LAT);
    single("rot_r", 1, 8'h81, 3'd1, DIR_RIGHT, 1'b1, ROT_R, ROT_LAT);
    single("rot_a0", 3, 8'h81, 3'd0, DIR_LEFT, 1'b1, 8'h81, 2);

    // All four held valid; pointer is back at 0
    for (int s = 0; s < 6; s++) begin
      case (order[s])
        0: expect_resp(0, 8'h44);
        1: expect_resp(1, 8'h0F);
        2: expect_resp(2, 8'h80);
        default: expect_resp(3, 8'h55);
      endcase
    end
    set_req(0, 8'h11, 3'd2, DIR_LEFT, 1'b0);
    set_req(1, 8'hF0, 3'd4, DIR_RIGHT, 1'b0);
    set_req(2, 8'h01, 3'd7, DIR_LEFT, 1'b0);
    set_req(3, 8'hAA, 3'd1, DIR_RIGHT, 1'b0);
    for (int s = 0; s < 6; s++) begin
      wait_grant(g);
      check("rr_order", 32'(g), 32'(order[s]));
      if (s >= 2 && g >= 0) req_valid[g] = 1'b0;
    end
    req_valid = '0;
    repeat (6) @(posedge Clock);
    #1;

    // Backpressure: hold RESP for 5 cycles while requester 3 waits
    resp_ready = 1'b0;
    expect_resp(1, 8'h78);
    set_req(1, 8'h0F, 3'd3, DIR_LEFT, 1'b0);
    wait_grant(g);
    req_valid[1] = 1'b0;
    check("bp_grant", 32'(g), 32'd1);
    expect_resp(3, 8'h0F);
    set_req(3, 8'h3C, 3'd2, DIR_RIGHT, 1'b0);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge Clock);
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge Clock);
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_resp_id", 32'(resp_id), 32'd1);
      check("bp_resp_data", 32'(resp_data), 32'h78);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
    end
    @(posedge Clock);
    #1;
    resp_ready = 1'b1;
    @(posedge Clock);
    #1;
    @(negedge Clock);
    check("bp_idle_ready", 32'(req_ready), 32'b1000);
    check("bp_idle_valid", 32'(resp_valid), 32'd0);
    check("bp_idle_busy", 32'(busy), 32'd0);
    @(posedge Clock);
    #1;
    req_valid[3] = 1'b0;
    repeat (5) @(posedge Clock);
    #1;

    // Reset during CAPTURE drops the request and clears the pointer
    set_req(2, 8'h55, 3'd1, DIR_LEFT, 1'b0);
    wait_grant(g);
    req_valid[2] = 1'b0;
    check("ar_grant", 32'(g), 32'd2);
    @(posedge Clock);
    @(negedge Clock);
    Reset_n = 1'b0;
    #1;
    check("ar_resp_valid", 32'(resp_valid), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_sh_data_in", 32'(sh_data_in), 32'd0);
    check("ar_resp_id", 32'(resp_id), 32'd0);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset_n = 1'b1;
    @(posedge Clock);
    #1;
    expect_resp(1, 8'h60);
    expect_resp(3, 8'h03);
    set_req(1, 8'h03, 3'd5, DIR_LEFT, 1'b0);
    set_req(3, 8'hC0, 3'd6, DIR_RIGHT, 1'b0);
    wait_grant(g);
    check("ar_first_grant", 32'(g), 32'd1);
    req_valid[1] = 1'b0;
    wait_grant(g);
    check("ar_second_grant", 32'(g), 32'd3);
    req_valid[3] = 1'b0;
    repeat (8) @(posedge Clock);
    #1;

    check("sb_drain", 32'(exp_id_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
